// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 multiply-accumulate sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // X mux in [1:0], Z mux in [3:2]; pre-adder, carry and post-subtract bits stay 0.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef struct packed {
    logic beat;
    logic first;
  } tag_t;

  function automatic logic [7:0] opmode_of(input tag_t t);
    if (t.first) return OPM_FIRST;
    if (t.beat)  return OPM_ACC;
    return OPM_HOLD;
  endfunction

endpackage

// File: rtl/dsp_seq_align.sv
// ALIGN-deep delay line carrying per-beat tags so OPMODE lines up with the slice's M register.
module dsp_seq_align
  import dsp_seq_pkg::*;
#(
  parameter int ALIGN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [ALIGN-1:0] stage_q;
  tag_t [ALIGN-1:0] stage_d;

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < ALIGN; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: state is updated with <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[ALIGN-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a length-programmable MAC; result captured after the pipeline drains.
// Optional DSP_SEQ_OVF_EN adds a sticky res_ovf output.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9,
  parameter int ALIGN   = 2,
  parameter int DRAIN   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_data,
  input  logic [17:0]      b_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic [47:0]      res_data,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef DSP_SEQ_OVF_EN
  output logic             res_ovf,
`endif
  output logic             busy
);

  localparam int               CNT_W     = $clog2(ALIGN + DRAIN + 1);
  localparam logic [CNT_W-1:0] DRAIN_CYC = CNT_W'(ALIGN + DRAIN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               first_q, first_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               ce_q, ce_d;
  logic               rstp_q, rstp_d;
  logic               res_valid_q, res_valid_d;
  logic [47:0]        res_data_q, res_data_d;
  logic [17:0]        dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  logic [LEN_W-1:0]   len_eff;
  logic               accept, job_start;
  tag_t               tag_in, tag_out;

  assign len_eff = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
  assign accept  = (state_q == ST_RUN) && in_valid && in_ready_q;

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    first_d     = first_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    dsp_a_d     = '0;
    dsp_b_d     = '0;
    tag_in      = '0;
    job_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          job_start = 1'b1;
          if (len_eff != '0) begin
            state_d    = ST_RUN;
            beat_cnt_d = len_eff;
            first_d    = 1'b1;
          end else begin
            state_d     = ST_DONE;
            res_data_d  = '0;
            res_valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          dsp_a_d    = a_data;
          dsp_b_d    = b_data;
          tag_in     = '{beat: 1'b1, first: first_q};
          first_d    = 1'b0;
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_CYC;
          end
        end
      end
      ST_DRAIN: begin
        // Delay line keeps flushing HOLD tags until P carries the final sum.
        if (drain_cnt_q == '0) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    ce_d       = busy_d;
    rstp_d     = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      ce_q        <= 1'b0;
      rstp_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      ce_q        <= ce_d;
      rstp_q      <= rstp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
    end
  end

  dsp_seq_align #(.ALIGN(ALIGN)) u_align (
    .clk     (clk),
    .rst     (rst),
    .clr     (job_start),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_opmode = opmode_of(tag_out);
  assign dsp_cea    = ce_q;
  assign dsp_ceb    = ce_q;
  assign dsp_cem    = ce_q;
  assign dsp_cep    = ce_q;
  assign dsp_rstp   = rstp_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;

`ifdef DSP_SEQ_OVF_EN
  // Beat tag delayed two more cycles so it lines up with the P update it caused.
  logic [1:0] ovf_beat_q, ovf_beat_d;
  logic       ovf_sign_q, ovf_sign_d;
  logic       res_ovf_q, res_ovf_d;

  always_comb begin
    ovf_beat_d = {ovf_beat_q[0], tag_out.beat};
    ovf_sign_d = dsp_p[47];
    res_ovf_d  = res_ovf_q;
    if (job_start) begin
      res_ovf_d = 1'b0;
    end else if (ovf_beat_q[1] && (dsp_carryout ^ (dsp_p[47] ^ ovf_sign_q))) begin
      res_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_beat_q <= '0;
      ovf_sign_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      ovf_beat_q <= ovf_beat_d;
      ovf_sign_q <= ovf_sign_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign res_ovf = res_ovf_q;
`else
  logic unused_carryout;
  assign unused_carryout = dsp_carryout;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP48A1 (A/B, M, OPMODE and P registers enabled).
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      a_data = '0;
  logic [17:0]      b_data = '0;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstp;
  logic [47:0]      dsp_p;
  logic             dsp_carryout;
  logic [47:0]      res_data;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             busy;
`ifdef DSP_SEQ_OVF_EN
  logic             res_ovf;
`endif

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.MAX_LEN(256), .LEN_W(LEN_W), .ALIGN(2), .DRAIN(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_data       (a_data),
    .b_data       (b_data),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_cea      (dsp_cea),
    .dsp_ceb      (dsp_ceb),
    .dsp_cem      (dsp_cem),
    .dsp_cep      (dsp_cep),
    .dsp_rstp     (dsp_rstp),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
`ifdef DSP_SEQ_OVF_EN
    .res_ovf      (res_ovf),
`endif
    .busy         (busy)
  );

  // Behavioural slice: A/B reg -> M reg -> P reg, OPMODE registered alongside M.
  logic signed [17:0] s_a = '0, s_b = '0;
  logic signed [35:0] s_m = '0;
  logic [7:0]         s_opm = OPM_HOLD;
  logic [47:0]        s_p = '0;
  logic               s_co = 1'b0;
  logic [47:0]        s_x, s_z;
  logic [48:0]        s_sum;

  always_comb begin
    s_x   = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
    s_sum = {1'b0, s_x} + {1'b0, s_z};
  end

  always @(posedge clk) begin
    if (dsp_cea) s_a <= dsp_a;
    if (dsp_ceb) s_b <= dsp_b;
    if (dsp_cem) s_m <= s_a * s_b;
    s_opm <= dsp_opmode;
    if (dsp_rstp) begin
      s_p  <= '0;
      s_co <= 1'b0;
    end else if (dsp_cep) begin
      s_p  <= s_sum[47:0];
      s_co <= s_sum[48];
    end
  end

  assign dsp_p        = s_p;
  assign dsp_carryout = s_co;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_res = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops the oldest expected value.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL res_unexpected: got 0x%0h expected no result", res_data);
      end else begin
        check("res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    step();
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    a_data   = a;
    b_data   = b;
    for (int i = 0; i < 40 && !got; i++) begin
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 30) begin
      step();
      n++;
    end
    check(name, 64'(n), 64'd6);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) step();
    check(name, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_busy",     {63'd0, busy},      64'd0);
    check("rst_in_ready", {63'd0, in_ready},  64'd0);
    check("rst_valid",    {63'd0, res_valid}, 64'd0);
    check("rst_cea",      {63'd0, dsp_cea},   64'd0);
    check("rst_rstp",     {63'd0, dsp_rstp},  64'd1);
    check("rst_opmode",   {56'd0, dsp_opmode}, {56'd0, OPM_HOLD});
    check("rst_res_data", {16'd0, res_data},  64'd0);
    check("rst_dsp_a",    {46'd0, dsp_a},     64'd0);

    // 1: len 4, no bubbles -> 70, res_valid 6 cycles after last accept
    start_job(4);
    check("t1_rstp_run", {63'd0, dsp_rstp}, 64'd0);
    exp_q.push_back(48'd70);
    send_beat(18'sd1, 18'sd5);
    send_beat(18'sd2, 18'sd6);
    send_beat(18'sd3, 18'sd7);
    send_beat(18'sd4, 18'sd8);
    check("t1_in_ready_drop", {63'd0, in_ready}, 64'd0);
    wait_result("t1_latency");
    wait_idle("t1_idle");

    // 2: len 3 with two bubble cycles between beats -> 174
    start_job(3);
    exp_q.push_back(48'd174);
    send_beat(18'sd10, 18'sd20);
    repeat (2) begin
      check("t2_in_ready_bubble", {63'd0, in_ready}, 64'd1);
      step();
    end
    send_beat(-18'sd3, 18'sd4);
    repeat (2) begin
      check("t2_in_ready_bubble", {63'd0, in_ready}, 64'd1);
      step();
    end
    res_ready = 1'b0;
    send_beat(18'sd7, -18'sd2);
    check("t2_in_ready_drop", {63'd0, in_ready}, 64'd0);
    wait_result("t2_latency");
    repeat (3) begin
      step();
      check("t2_hold_valid", {63'd0, res_valid}, 64'd1);
      check("t2_hold_data", {16'd0, res_data}, 64'd174);
    end
    res_ready = 1'b1;
    step();
    wait_idle("t2_idle");

    // 3: cfg_len 0 -> immediate zero result, held while res_ready is low
    res_ready = 1'b0;
    start_job(0);
    exp_q.push_back(48'd0);
    repeat (5) begin
      check("t3_valid", {63'd0, res_valid}, 64'd1);
      check("t3_data", {16'd0, res_data}, 64'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    wait_idle("t3_idle");

    // 4: abort mid-job with rst, then a clean len 2 job -> 12
    start_job(5);
    send_beat(18'sd100, 18'sd100);
    send_beat(18'sd50, -18'sd7);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("t4_busy",     {63'd0, busy},      64'd0);
    check("t4_in_ready", {63'd0, in_ready},  64'd0);
    check("t4_rstp",     {63'd0, dsp_rstp},  64'd1);
    check("t4_opmode",   {56'd0, dsp_opmode}, {56'd0, OPM_HOLD});
    start_job(2);
    exp_q.push_back(48'd12);
    send_beat(18'sd2, 18'sd3);
    send_beat(18'sd2, 18'sd3);
    wait_result("t4_latency");
    wait_idle("t4_idle");

    // 5: back-to-back jobs, start during the first one ignored
    start_job(2);
    exp_q.push_back(48'd34359214082);
    send_beat(18'sd131071, 18'sd131071);
    start   = 1'b1;
    cfg_len = LEN_W'(7);
    send_beat(18'sd131071, 18'sd131071);
    start   = 1'b0;
    wait_result("t5a_latency");
    wait_idle("t5a_idle");
    step();
    check("t5_no_ghost_job", {63'd0, busy}, 64'd0);
    start_job(1);
    exp_q.push_back(48'hFFFF_FFFE_0000);
    send_beat(-18'sd131072, 18'sd1);
    wait_result("t5b_latency");
    wait_idle("t5b_idle");

    repeat (4) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_res), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
